// File: rtl/keyboard_scanner_debounced_pkg.sv
// Shared definitions for the keypad scanner slice: matrix defaults, width helpers,
// scanner FSM encoding and the event word layout {press, code}.
package keyboard_scanner_debounced_pkg;

  localparam int KEYBOARD_ROWS = 4;
  localparam int KEYBOARD_COLS = 4;

  // Smallest n with 2**n >= value; usable in parameter expressions.
  function automatic int kb_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Event word is {press, code}: press in the MSB, key index below it.
  function automatic int kb_evt_width(input int key_w);
    return key_w + 1;
  endfunction

  typedef enum logic [0:0] {
    KB_SAMPLE = 1'b0,
    KB_COMMIT = 1'b1
  } kb_state_e;

endpackage

// File: rtl/keyboard_scanner_debounced_if.sv
// Key event stream between the scanner and the application logic.
interface keyboard_scanner_debounced_if #(
  parameter int KEY_W = 4
);
  // valid/ready: the source holds evt_valid, evt_code and evt_press stable until a
  // cycle where evt_valid && evt_ready, which transfers the word; evt_ready may change
  // freely and has no effect while evt_valid is low.
  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_code;
  logic             evt_press;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_press,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_press,
    output evt_ready
  );

endinterface

// File: rtl/keyboard_scanner_debounced_kb_event_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO is still accepted
// when the head is popped in the same cycle. head reads zero while empty.
module kb_event_fifo
  import keyboard_scanner_debounced_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  localparam int PTR_W = kb_clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ok,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && ((count_q < CNT_W'(DEPTH)) || pop_ok);
  assign head    = empty ? '0 : mem_q[rd_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/keyboard_scanner_debounced.sv
// Debounced matrix keypad scanner: one row per SAMPLE cycle, one COMMIT cycle per
// key that flips, press/release events queued in order of key index within a frame.
module keyboard_scanner_debounced
  import keyboard_scanner_debounced_pkg::*;
#(
  parameter int ROWS           = KEYBOARD_ROWS,
  parameter int COLS           = KEYBOARD_COLS,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8,
  localparam int NKEYS  = ROWS * COLS,
  localparam int KEY_W  = kb_clog2(NKEYS),
  localparam int ROW_W  = kb_clog2(ROWS),
  localparam int CNT_W  = kb_clog2(DEBOUNCE_SCANS + 1),
  localparam int CNT1_W = CNT_W + 1,
  localparam int EVT_W  = kb_evt_width(KEY_W),
  localparam int FCNT_W = kb_clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_kb,
  input  logic                 reset_n,
  output logic [ROWS-1:0]      kb_row,
  input  logic [COLS-1:0]      kb_col,
  output logic [NKEYS-1:0]     keys,
  keyboard_scanner_debounced_if.master evt,
  output logic                 overflow,
  output logic                 scan_done,
  output kb_state_e            dbg_state,
  output logic [FCNT_W-1:0]    dbg_fifo_count
);

  kb_state_e                  state_q, state_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [ROWS-1:0]            kb_row_q, kb_row_d;
  logic [NKEYS-1:0]           keys_q, keys_d;
  logic [NKEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [COLS-1:0]            pend_q, pend_d;
  logic [COLS-1:0]            col_latch_q, col_latch_d;
  logic                       overflow_q, overflow_d;
  logic                       scan_done_q, scan_done_d;

  logic [COLS-1:0]            raw;
  logic                       last_row;
  logic                       advance;
  logic                       taken;
  logic [KEY_W-1:0]           key_idx;
  logic                       push;
  logic [EVT_W-1:0]           push_data;
  logic                       push_ok;
  logic [EVT_W-1:0]           head;
  logic                       fifo_empty;

  function automatic logic [KEY_W-1:0] key_of(input logic [ROW_W-1:0] row, input int col);
    return KEY_W'(int'(row) * COLS + col);
  endfunction

  assign raw      = ~kb_col;
  assign last_row = (row_q == ROW_W'(ROWS - 1));

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    keys_d      = keys_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    col_latch_d = col_latch_q;
    advance     = 1'b0;
    taken       = 1'b0;
    key_idx     = '0;
    push        = 1'b0;
    push_data   = '0;

    case (state_q)
      KB_SAMPLE: begin
        col_latch_d = raw;
        pend_d      = '0;
        for (int c = 0; c < COLS; c++) begin
          key_idx = key_of(row_q, c);
          if (raw[c] == keys_q[key_idx]) begin
            cnt_d[key_idx] = '0;
          end else begin
            // The frame that completes the run of differing samples flips the key.
            if (({1'b0, cnt_q[key_idx]} + 1'b1) == CNT1_W'(DEBOUNCE_SCANS)) begin
              pend_d[c] = 1'b1;
            end
            if (cnt_q[key_idx] != CNT_W'(DEBOUNCE_SCANS)) begin
              cnt_d[key_idx] = cnt_q[key_idx] + 1'b1;
            end
          end
        end
        if (pend_d == '0) begin
          advance = 1'b1;
        end else begin
          state_d = KB_COMMIT;
        end
      end

      KB_COMMIT: begin
        // Row stays driven; the latched columns give the new level of each key.
        for (int c = 0; c < COLS; c++) begin
          if (pend_q[c] && !taken) begin
            taken           = 1'b1;
            key_idx         = key_of(row_q, c);
            keys_d[key_idx] = col_latch_q[c];
            cnt_d[key_idx]  = '0;
            push            = 1'b1;
            push_data       = {col_latch_q[c], key_idx};
            pend_d[c]       = 1'b0;
          end
        end
        if (pend_d == '0) begin
          advance = 1'b1;
          state_d = KB_SAMPLE;
        end
      end

      default: begin
        state_d = KB_SAMPLE;
      end
    endcase

    if (advance) begin
      row_d = last_row ? '0 : row_q + 1'b1;
    end
    kb_row_d    = ~(ROWS'(1) << row_d);
    scan_done_d = advance && last_row;
    overflow_d  = overflow_q | (push & ~push_ok);
  end

  always_ff @(posedge clk_kb or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= KB_SAMPLE;
      row_q       <= '0;
      kb_row_q    <= ~ROWS'(1);
      keys_q      <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      col_latch_q <= '0;
      overflow_q  <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      kb_row_q    <= kb_row_d;
      keys_q      <= keys_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      col_latch_q <= col_latch_d;
      overflow_q  <= overflow_d;
      scan_done_q <= scan_done_d;
    end
  end

  kb_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_kb),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .push_ok   (push_ok),
    .pop       (evt.evt_ready),
    .head      (head),
    .empty     (fifo_empty),
    .count     (dbg_fifo_count)
  );

  assign evt.evt_valid                 = !fifo_empty;
  assign {evt.evt_press, evt.evt_code} = head;

  assign kb_row    = kb_row_q;
  assign keys      = keys_q;
  assign overflow  = overflow_q;
  assign scan_done = scan_done_q;
  assign dbg_state = state_q;

endmodule
